// File: rtl/conv_layer_sequencer.sv
// ---------------------------------------------------------------------------
// conv_layer_sequencer
//
// Runs a list of convolution layers back to back on the conv core. A host
// loads per-layer descriptors into a small table. A one-cycle run then walks
// layers 0..num_layers-1. For each layer the sequencer loads the descriptor
// onto the core config outputs, validates it, and pulses core_start. It then
// waits for a rising edge on core_done, guarded by a watchdog.
//
// Ports
//   clk, resetn          clock, asynchronous active-low reset
//   cfg_we/addr/wdata    descriptor write port. Honoured only when the
//                        sequencer is not busy. Packed fields:
//                        [43:41]K [40:27]IC [26:21]IMG_H [20:15]IMG_W
//                        [14:7]OC [6:4]stride [3:0]shift_n
//   num_layers           layers to run, sampled when run is accepted
//   run / abort / err_clr  launch, abort and error-acknowledge controls
//   core_done            done from the core; only its rising edge is used
//   core_start           one-cycle start pulse to the core
//   core_*               descriptor fields driven to the core
//   busy                 high in LOAD, CHECK, START, WAIT and NEXT
//   cur_layer            index of the layer in progress
//   seq_done             one-cycle pulse when the whole list has finished
//   err, err_code        1 bad descriptor, 2 timeout, 3 abort
// ---------------------------------------------------------------------------
module conv_layer_sequencer #(
    parameter int MAX_LAYERS  = 16,
    parameter int LAYER_AW    = 4,
    parameter int TO_W        = 24,
    parameter int TIMEOUT_CYC = 3000000
) (
    input  logic                clk,
    input  logic                resetn,
    input  logic                cfg_we,
    input  logic [LAYER_AW-1:0] cfg_addr,
    input  logic [43:0]         cfg_wdata,
    input  logic [LAYER_AW:0]   num_layers,
    input  logic                run,
    input  logic                abort,
    input  logic                err_clr,
    input  logic                core_done,
    output logic                core_start,
    output logic [2:0]          core_K,
    output logic [13:0]         core_IC,
    output logic [5:0]          core_IMG_H,
    output logic [5:0]          core_IMG_W,
    output logic [7:0]          core_OC,
    output logic [2:0]          core_stride,
    output logic [3:0]          core_shift_n,
    output logic                busy,
    output logic [LAYER_AW-1:0] cur_layer,
    output logic                seq_done,
    output logic                err,
    output logic [1:0]          err_code
);

    typedef enum logic [2:0] {
        S_IDLE, S_LOAD, S_CHECK, S_START, S_WAIT, S_NEXT, S_DONE, S_ERR
    } state_t;

    state_t                state_reg, state_next;
    logic [43:0]           table_reg [MAX_LAYERS];
    logic [MAX_LAYERS-1:0] table_we;
    logic                  tbl_we;
    logic [LAYER_AW-1:0]   idx_reg, idx_next;
    logic [LAYER_AW:0]     num_reg, num_next;
    logic [TO_W-1:0]       wd_reg, wd_next;
    logic [1:0]            err_code_reg, err_code_next;
    logic                  done_d_reg;
    logic                  done_rise;
    logic                  core_start_reg;
    logic                  seq_done_reg;
    logic                  desc_valid;

    logic [2:0]            k_reg;
    logic [13:0]           ic_reg;
    logic [5:0]            h_reg;
    logic [5:0]            w_reg;
    logic [7:0]            oc_reg;
    logic [2:0]            stride_reg;
    logic [3:0]            shift_reg;

    assign busy = (state_reg == S_LOAD) || (state_reg == S_CHECK) ||
                  (state_reg == S_START) || (state_reg == S_WAIT) ||
                  (state_reg == S_NEXT);
    assign err  = (state_reg == S_ERR);

    // ------------------------------------------------------------------
    // Descriptor table. It is cleared by reset, so it is kept in flops
    // rather than RAM.
    // ------------------------------------------------------------------
    assign tbl_we = cfg_we && !busy && (int'(cfg_addr) < MAX_LAYERS);

    genvar gi;
    generate
        for (gi = 0; gi < MAX_LAYERS; gi++) begin : g_we
            assign table_we[gi] = tbl_we && (cfg_addr == LAYER_AW'(gi));
        end
    endgenerate

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < MAX_LAYERS; i++) table_reg[i] <= '0;
        end else begin
            for (int i = 0; i < MAX_LAYERS; i++)
                if (table_we[i]) table_reg[i] <= cfg_wdata;
        end
    end

    // Validation runs on the registered core fields. This keeps the table
    // mux and the compare chain in separate cycles.
    assign desc_valid = k_reg[0] &&
                        (ic_reg != '0) && (oc_reg != '0) &&
                        (stride_reg >= 3'd1) && (stride_reg <= 3'd4) &&
                        (h_reg >= {3'b000, k_reg}) && (w_reg >= {3'b000, k_reg});

    // A done that is already high when WAIT is entered is not an edge.
    assign done_rise = core_done && !done_d_reg;

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_next    = state_reg;
        idx_next      = idx_reg;
        num_next      = num_reg;
        wd_next       = wd_reg;
        err_code_next = err_code_reg;
        case (state_reg)
            S_IDLE: begin
                if (run) begin
                    if (num_layers != '0) begin
                        // Clamp so that idx can never run past the table.
                        num_next   = (int'(num_layers) > MAX_LAYERS) ?
                                     (LAYER_AW+1)'(MAX_LAYERS) : num_layers;
                        idx_next   = '0;
                        state_next = S_LOAD;
                    end else begin
                        state_next = S_DONE;
                    end
                end
            end
            S_LOAD: begin
                if (abort) begin
                    state_next    = S_ERR;
                    err_code_next = 2'd3;
                end else begin
                    state_next = S_CHECK;
                end
            end
            S_CHECK: begin
                if (abort) begin
                    state_next    = S_ERR;
                    err_code_next = 2'd3;
                end else if (!desc_valid) begin
                    state_next    = S_ERR;
                    err_code_next = 2'd1;
                end else begin
                    state_next = S_START;
                end
            end
            S_START: begin
                wd_next = '0;
                if (abort) begin
                    state_next    = S_ERR;
                    err_code_next = 2'd3;
                end else begin
                    state_next = S_WAIT;
                end
            end
            S_WAIT: begin
                if (abort) begin
                    state_next    = S_ERR;
                    err_code_next = 2'd3;
                end else if (done_rise) begin
                    state_next = S_NEXT;
                end else if (wd_reg == TO_W'(TIMEOUT_CYC - 1)) begin
                    state_next    = S_ERR;
                    err_code_next = 2'd2;
                end else begin
                    wd_next = wd_reg + TO_W'(1);
                end
            end
            S_NEXT: begin
                if (abort) begin
                    state_next    = S_ERR;
                    err_code_next = 2'd3;
                end else if ({1'b0, idx_reg} == num_reg - (LAYER_AW+1)'(1)) begin
                    state_next = S_DONE;
                end else begin
                    idx_next   = idx_reg + LAYER_AW'(1);
                    state_next = S_LOAD;
                end
            end
            S_DONE: state_next = S_IDLE;
            S_ERR: begin
                if (err_clr) begin
                    state_next    = S_IDLE;
                    err_code_next = 2'd0;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // State and datapath registers. core_start and seq_done come straight
    // from flops, so they cannot glitch.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_reg      <= S_IDLE;
            idx_reg        <= '0;
            num_reg        <= '0;
            wd_reg         <= '0;
            err_code_reg   <= '0;
            done_d_reg     <= 1'b0;
            core_start_reg <= 1'b0;
            seq_done_reg   <= 1'b0;
            k_reg          <= '0;
            ic_reg         <= '0;
            h_reg          <= '0;
            w_reg          <= '0;
            oc_reg         <= '0;
            stride_reg     <= '0;
            shift_reg      <= '0;
        end else begin
            state_reg      <= state_next;
            idx_reg        <= idx_next;
            num_reg        <= num_next;
            wd_reg         <= wd_next;
            err_code_reg   <= err_code_next;
            done_d_reg     <= core_done;
            core_start_reg <= (state_next == S_START);
            seq_done_reg   <= (state_next == S_DONE);
            // The core config only changes when a layer is loaded. It
            // holds through WAIT and ERR.
            if (state_reg == S_LOAD && state_next == S_CHECK) begin
                {k_reg, ic_reg, h_reg, w_reg, oc_reg, stride_reg, shift_reg}
                    <= table_reg[idx_reg];
            end
        end
    end

    assign core_start   = core_start_reg;
    assign seq_done     = seq_done_reg;
    assign err_code     = err_code_reg;
    assign cur_layer    = idx_reg;
    assign core_K       = k_reg;
    assign core_IC      = ic_reg;
    assign core_IMG_H   = h_reg;
    assign core_IMG_W   = w_reg;
    assign core_OC      = oc_reg;
    assign core_stride  = stride_reg;
    assign core_shift_n = shift_reg;

endmodule
